cpu_ctrl_fsm: RTL and testbench

Multicycle control state machine for the ARMv7-subset CPU. It sequences fetch, decode, execute, memory and write-back. It drives the instruction-register write enable, the PC update and the register-file, CPSR and data-memory enables. It consumes the condition-pass flag computed by the instruction register from Inst[31:28] and NZCV, and skips failed-condition instructions in two cycles. It also keeps retired and skipped instruction counters for bring-up on the board.

---
 rtl/cpu_ctrl_pkg.sv | 89 ++++++++
 rtl/cpu_ctrl_fsm_if.sv | 35 +++
 rtl/cpu_ctrl_fsm_perf_cnt.sv | 28 ++
 rtl/cpu_ctrl_fsm.sv | 133 +++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and the per-state output decode for the multicycle CPU controller.
// Output strobes are produced as one packed struct so the FSM can register them in one step.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        OP_DP    = 2'b00,
        OP_LS    = 2'b01,
        OP_BR    = 2'b10,
        OP_UNDEF = 2'b11
    } op_class_e;

    // 2'b10 is reserved and never driven by this controller
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;

    localparam logic [3:0] REG_LR = 4'd14;

    typedef struct packed {
        logic       write_ir;
        logic       write_pc;
        logic [1:0] pc_src;
        logic       rf_rd_en;
        logic       alu_en;
        logic       write_cpsr;
        logic       mem_read;
        logic       mem_write;
        logic       write_reg;
        logic       reg_dst_lr;
        logic       reg_src;
        logic       undef;
    } ctrl_out_t;

    function automatic ctrl_out_t state_outputs(
        input ctrl_state_e st,
        input logic        take_undef,
        input logic [1:0]  op_class,
        input logic        s_bit,
        input logic        ls_load,
        input logic        link
    );
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_FETCH: begin
                o.write_ir = 1'b1;
                o.write_pc = 1'b1;
                o.pc_src   = PC_SRC_SEQ;
            end
            ST_DECODE: begin
                o.rf_rd_en = 1'b1;
                o.undef    = take_undef;
            end
            ST_EXEC: begin
                o.alu_en     = 1'b1;
                o.write_cpsr = (op_class == OP_DP) ? s_bit : 1'b0;
            end
            ST_MEM: begin
                o.mem_read  = ls_load;
                o.mem_write = ~ls_load;
            end
            ST_WB: begin
                o.write_reg = 1'b1;
                o.reg_src   = (op_class == OP_LS) ? 1'b1 : 1'b0;
            end
            ST_BRANCH: begin
                // the ALU already carries the return address, so Reg_src stays 0
                o.write_pc   = 1'b1;
                o.pc_src     = PC_SRC_BR;
                o.write_reg  = link;
                o.reg_dst_lr = link;
                o.reg_src    = 1'b0;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the CPU controller (master) and the datapath (slave):
// decoded instruction fields and memory handshake in, enables and strobes out.
interface cpu_ctrl_if;
    logic       flag;
    logic [1:0] op_class;
    logic       ls_load;
    logic       s_bit;
    logic       link;
    logic       mem_ready;

    logic       Write_IR;
    logic       Write_PC;
    logic [1:0] PC_src;
    logic       rf_rd_en;
    logic       alu_en;
    logic       Write_CPSR;
    logic       Mem_Read;
    logic       Mem_Write;
    logic       Write_Reg;
    logic       Reg_dst_lr;
    logic       Reg_src;
    logic       undef;

    modport master (
        input  flag, op_class, ls_load, s_bit, link, mem_ready,
        output Write_IR, Write_PC, PC_src, rf_rd_en, alu_en, Write_CPSR,
               Mem_Read, Mem_Write, Write_Reg, Reg_dst_lr, Reg_src, undef
    );

    modport slave (
        output flag, op_class, ls_load, s_bit, link, mem_ready,
        input  Write_IR, Write_PC, PC_src, rf_rd_en, alu_en, Write_CPSR,
               Mem_Read, Mem_Write, Write_Reg, Reg_dst_lr, Reg_src, undef
    );
endinterface

// File: rtl/cpu_ctrl_fsm_perf_cnt.sv
// Wrapping event counter with increment enable and asynchronous clear.
module ctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // counter register, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle fetch/decode/execute/memory/write-back sequencer with registered Moore
// outputs and retired/skipped instruction counters.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    cpu_ctrl_if.master       bus,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] skipped_cnt
);

    ctrl_state_e state_r;
    ctrl_state_e next_state_s;
    logic        cond_pass_r;
    logic        cond_next_s;
    logic        run_r;
    logic        take_undef_s;
    logic        ret_inc_s;
    logic        skip_inc_s;
    ctrl_out_t   out_r;

    // next-state and counter-event decode; outputs are looked up for the next state
    always_comb begin
        next_state_s = ST_FETCH;
        cond_next_s  = cond_pass_r;
        take_undef_s = 1'b0;
        ret_inc_s    = 1'b0;
        skip_inc_s   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                // first edge after reset only raises the fetch strobes
                if (run_r) begin
                    next_state_s = ST_DECODE;
                    cond_next_s  = bus.flag;
                    take_undef_s = bus.flag & (bus.op_class == OP_UNDEF);
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!cond_pass_r) begin
                    next_state_s = ST_FETCH;
                    skip_inc_s   = 1'b1;
                end else begin
                    case (bus.op_class)
                        OP_DP:    next_state_s = ST_EXEC;
                        OP_LS:    next_state_s = ST_EXEC;
                        OP_BR:    next_state_s = ST_BRANCH;
                        OP_UNDEF: next_state_s = ST_FETCH;
                        default:  next_state_s = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC: begin
                if (bus.op_class == OP_LS) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (!bus.mem_ready) begin
                    next_state_s = ST_MEM;
                end else if (bus.ls_load) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                    ret_inc_s    = 1'b1;
                end
            end
            ST_WB: begin
                next_state_s = ST_FETCH;
                ret_inc_s    = 1'b1;
            end
            ST_BRANCH: begin
                next_state_s = ST_FETCH;
                ret_inc_s    = 1'b1;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // state, condition latch and registered strobes; reset clears strobes asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            cond_pass_r <= 1'b0;
            run_r       <= 1'b0;
            out_r       <= '0;
        end else begin
            state_r     <= next_state_s;
            cond_pass_r <= cond_next_s;
            run_r       <= 1'b1;
            out_r       <= state_outputs(next_state_s, take_undef_s, bus.op_class,
                                         bus.s_bit, bus.ls_load, bus.link);
        end
    end

    ctrl_perf_cnt #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (ret_inc_s),
        .count (retired_cnt)
    );

    ctrl_perf_cnt #(.CNT_W(CNT_W)) u_skipped_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (skip_inc_s),
        .count (skipped_cnt)
    );

    assign state          = state_r;
    assign bus.Write_IR   = out_r.write_ir;
    assign bus.Write_PC   = out_r.write_pc;
    assign bus.PC_src     = out_r.pc_src;
    assign bus.rf_rd_en   = out_r.rf_rd_en;
    assign bus.alu_en     = out_r.alu_en;
    assign bus.Write_CPSR = out_r.write_cpsr;
    assign bus.Mem_Read   = out_r.mem_read;
    assign bus.Mem_Write  = out_r.mem_write;
    assign bus.Write_Reg  = out_r.write_reg;
    assign bus.Reg_dst_lr = out_r.reg_dst_lr;
    assign bus.Reg_src    = out_r.reg_src;
    assign bus.undef      = out_r.undef;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus queues hand-computed per-cycle expectations,
// a monitor pops them after each rising edge (or on demand) and compares.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    // strobe vector: WIR WPC PC_src[1:0] rf_rd alu CPSR MRd MWr WReg LR Rsrc undef
    localparam logic [12:0] X_ZERO    = 13'b0_0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] X_FETCH   = 13'b1_1_00_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] X_DEC     = 13'b0_0_00_1_0_0_0_0_0_0_0_0;
    localparam logic [12:0] X_DEC_UND = 13'b0_0_00_1_0_0_0_0_0_0_0_1;
    localparam logic [12:0] X_EXEC    = 13'b0_0_00_0_1_0_0_0_0_0_0_0;
    localparam logic [12:0] X_EXEC_S  = 13'b0_0_00_0_1_1_0_0_0_0_0_0;
    localparam logic [12:0] X_MEM_RD  = 13'b0_0_00_0_0_0_1_0_0_0_0_0;
    localparam logic [12:0] X_MEM_WR  = 13'b0_0_00_0_0_0_0_1_0_0_0_0;
    localparam logic [12:0] X_WB_ALU  = 13'b0_0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [12:0] X_WB_MEM  = 13'b0_0_00_0_0_0_0_0_1_0_1_0;
    localparam logic [12:0] X_BL      = 13'b0_1_01_0_0_0_0_0_1_1_0_0;
    localparam logic [12:0] X_B       = 13'b0_1_01_0_0_0_0_0_0_0_0_0;

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] strb;
        logic [31:0] ret;
        logic [31:0] skp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  state;
    logic [31:0] retired_cnt;
    logic [31:0] skipped_cnt;

    exp_t        exp_q[$];
    string       name_q[$];
    logic [31:0] exp_ret;
    logic [31:0] exp_skp;
    int          checks;
    int          passes;
    event        chk_ev;

    cpu_ctrl_if bus();

    cpu_ctrl_fsm #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state       (state),
        .retired_cnt (retired_cnt),
        .skipped_cnt (skipped_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input string nm, input logic [2:0] st, input logic [12:0] strb);
        exp_t e;
        e.st   = st;
        e.strb = strb;
        e.ret  = exp_ret;
        e.skp  = exp_skp;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // drive inputs at the falling edge; expectation is for the state after the next rising edge
    task automatic step(input string nm, input logic r, input logic fl, input logic [1:0] op,
                        input logic ld, input logic s, input logic lk, input logic rdy,
                        input logic [2:0] st, input logic [12:0] strb,
                        input logic dret, input logic dskp);
        @(negedge clk);
        rst           = r;
        bus.flag      = fl;
        bus.op_class  = op;
        bus.ls_load   = ld;
        bus.s_bit     = s;
        bus.link      = lk;
        bus.mem_ready = rdy;
        if (r) begin
            exp_ret = 32'd0;
            exp_skp = 32'd0;
        end else begin
            exp_ret = exp_ret + {31'd0, dret};
            exp_skp = exp_skp + {31'd0, dskp};
        end
        push(nm, st, strb);
    endtask

    // monitor: compare every queued expectation against the DUT
    initial begin
        exp_t        e;
        string       nm;
        logic [12:0] act;
        forever begin
            @(posedge clk or chk_ev);
            #2;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {bus.Write_IR, bus.Write_PC, bus.PC_src, bus.rf_rd_en, bus.alu_en,
                       bus.Write_CPSR, bus.Mem_Read, bus.Mem_Write, bus.Write_Reg,
                       bus.Reg_dst_lr, bus.Reg_src, bus.undef};
                checks = checks + 1;
                if (state === e.st && act === e.strb && retired_cnt === e.ret &&
                    skipped_cnt === e.skp) begin
                    passes = passes + 1;
                end else begin
                    $display("FAIL %s: got state=%0d strobes=%b ret=%0d skp=%0d, want state=%0d strobes=%b ret=%0d skp=%0d",
                             nm, state, act, retired_cnt, skipped_cnt, e.st, e.strb, e.ret, e.skp);
                end
            end
        end
    end

    initial begin
        checks = 0;
        passes = 0;
        exp_ret = 32'd0;
        exp_skp = 32'd0;
        rst = 1'b1;
        bus.flag = 1'b0;
        bus.op_class = 2'b00;
        bus.ls_load = 1'b0;
        bus.s_bit = 1'b0;
        bus.link = 1'b0;
        bus.mem_ready = 1'b0;
        $display("cpu_ctrl_fsm bench: link register is R%0d", REG_LR);

        //    name         rst fl op     ld s  lk rdy  state      strobes    ret skp
        step("reset",      1, 0, 2'b00, 0, 0, 0, 0, ST_FETCH,  X_ZERO,    0, 0);
        step("rel_fetch",  0, 0, 2'b00, 0, 0, 0, 0, ST_FETCH,  X_FETCH,   0, 0);
        // AL data-proc with S=1
        step("dp_dec",     0, 1, 2'b00, 1, 1, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("dp_exec",    0, 1, 2'b00, 1, 1, 0, 0, ST_EXEC,   X_EXEC_S,  0, 0);
        step("dp_wb",      0, 1, 2'b00, 1, 1, 0, 0, ST_WB,     X_WB_ALU,  0, 0);
        step("dp_ret",     0, 1, 2'b00, 1, 1, 0, 0, ST_FETCH,  X_FETCH,   1, 0);
        // failed condition; stale op_class=11 must not raise undef
        step("skp_dec",    0, 0, 2'b11, 0, 0, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("skp_ret",    0, 0, 2'b11, 0, 0, 0, 0, ST_FETCH,  X_FETCH,   0, 1);
        // LDR with three wait cycles
        step("ldr_dec",    0, 1, 2'b01, 1, 1, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("ldr_exec",   0, 1, 2'b01, 1, 1, 0, 0, ST_EXEC,   X_EXEC,    0, 0);
        step("ldr_mem",    0, 1, 2'b01, 1, 1, 0, 0, ST_MEM,    X_MEM_RD,  0, 0);
        step("ldr_wait1",  0, 1, 2'b01, 1, 1, 0, 0, ST_MEM,    X_MEM_RD,  0, 0);
        step("ldr_wait2",  0, 1, 2'b01, 1, 1, 0, 0, ST_MEM,    X_MEM_RD,  0, 0);
        step("ldr_wait3",  0, 1, 2'b01, 1, 1, 0, 0, ST_MEM,    X_MEM_RD,  0, 0);
        step("ldr_wb",     0, 1, 2'b01, 1, 1, 0, 1, ST_WB,     X_WB_MEM,  0, 0);
        step("ldr_ret",    0, 1, 2'b01, 1, 1, 0, 0, ST_FETCH,  X_FETCH,   1, 0);
        // BL
        step("bl_dec",     0, 1, 2'b10, 0, 0, 1, 0, ST_DECODE, X_DEC,     0, 0);
        step("bl_br",      0, 1, 2'b10, 0, 0, 1, 0, ST_BRANCH, X_BL,      0, 0);
        step("bl_ret",     0, 1, 2'b10, 0, 0, 1, 0, ST_FETCH,  X_FETCH,   1, 0);
        // undefined
        step("und_dec",    0, 1, 2'b11, 0, 0, 0, 0, ST_DECODE, X_DEC_UND, 0, 0);
        step("und_ret",    0, 1, 2'b11, 0, 0, 0, 0, ST_FETCH,  X_FETCH,   0, 0);
        // plain B
        step("b_dec",      0, 1, 2'b10, 0, 0, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("b_br",       0, 1, 2'b10, 0, 0, 0, 0, ST_BRANCH, X_B,       0, 0);
        step("b_ret",      0, 1, 2'b10, 0, 0, 0, 0, ST_FETCH,  X_FETCH,   1, 0);
        // STR with mem_ready already high: one MEM cycle
        step("str_dec",    0, 1, 2'b01, 0, 0, 0, 1, ST_DECODE, X_DEC,     0, 0);
        step("str_exec",   0, 1, 2'b01, 0, 0, 0, 1, ST_EXEC,   X_EXEC,    0, 0);
        step("str_mem",    0, 1, 2'b01, 0, 0, 0, 1, ST_MEM,    X_MEM_WR,  0, 0);
        step("str_ret",    0, 1, 2'b01, 0, 0, 0, 1, ST_FETCH,  X_FETCH,   1, 0);
        // data-proc with S=0
        step("dp0_dec",    0, 1, 2'b00, 0, 0, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("dp0_exec",   0, 1, 2'b00, 0, 0, 0, 0, ST_EXEC,   X_EXEC,    0, 0);
        step("dp0_wb",     0, 1, 2'b00, 0, 0, 0, 0, ST_WB,     X_WB_ALU,  0, 0);
        step("dp0_ret",    0, 1, 2'b00, 0, 0, 0, 0, ST_FETCH,  X_FETCH,   1, 0);
        // STR interrupted by reset while waiting in MEM
        step("sr_dec",     0, 1, 2'b01, 0, 0, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("sr_exec",    0, 1, 2'b01, 0, 0, 0, 0, ST_EXEC,   X_EXEC,    0, 0);
        step("sr_mem",     0, 1, 2'b01, 0, 0, 0, 0, ST_MEM,    X_MEM_WR,  0, 0);
        step("sr_wait",    0, 1, 2'b01, 0, 0, 0, 0, ST_MEM,    X_MEM_WR,  0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_ret = 32'd0;
        exp_skp = 32'd0;
        push("rst_async", ST_FETCH, X_ZERO);
        ->chk_ev;
        step("rst_hold",   1, 0, 2'b00, 0, 0, 0, 0, ST_FETCH,  X_ZERO,    0, 0);
        step("rst_rel",    0, 0, 2'b00, 0, 0, 0, 0, ST_FETCH,  X_FETCH,   0, 0);
        step("pr_dec",     0, 1, 2'b00, 1, 1, 0, 0, ST_DECODE, X_DEC,     0, 0);
        step("pr_exec",    0, 1, 2'b00, 1, 1, 0, 0, ST_EXEC,   X_EXEC_S,  0, 0);
        step("pr_wb",      0, 1, 2'b00, 1, 1, 0, 0, ST_WB,     X_WB_ALU,  0, 0);
        step("pr_ret",     0, 1, 2'b00, 1, 1, 0, 0, ST_FETCH,  X_FETCH,   1, 0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
